// File: rtl/studio2_keypad.sv
// Studio II hex-keypad front end: ps2_key events become two 10-key held bitmaps.
// OUT 2 latches the key select, which drives the active-low EF3/EF4 key-down flags.
module studio2_keypad (
    input  logic        clk,
    input  logic        resetq,
    input  logic [10:0] ps2_key,
    input  logic        clear_all,
    input  logic        io_out,
    input  logic [2:0]  io_n,
    input  logic [7:0]  io_dout,
    output logic        ef3_n,
    output logic        ef4_n,
    output logic [3:0]  key_sel,
    output logic [9:0]  kp1_state,
    output logic [9:0]  kp2_state
);

    logic       prev_tog;
    logic       primed;
    logic       key_event;
    logic       hit1;
    logic       hit2;
    logic [3:0] idx;
    logic [15:0] kp1_ext;
    logic [15:0] kp2_ext;

    // The toggle is consumed even for extended codes; only the decode is suppressed.
    assign key_event = primed && (ps2_key[10] != prev_tog) && !ps2_key[8];

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        idx  = 4'd0;
        case (ps2_key[7:0])
            8'h45: begin hit1 = 1'b1; idx = 4'd0; end
            8'h16: begin hit1 = 1'b1; idx = 4'd1; end
            8'h1E: begin hit1 = 1'b1; idx = 4'd2; end
            8'h26: begin hit1 = 1'b1; idx = 4'd3; end
            8'h25: begin hit1 = 1'b1; idx = 4'd4; end
            8'h2E: begin hit1 = 1'b1; idx = 4'd5; end
            8'h36: begin hit1 = 1'b1; idx = 4'd6; end
            8'h3D: begin hit1 = 1'b1; idx = 4'd7; end
            8'h3E: begin hit1 = 1'b1; idx = 4'd8; end
            8'h46: begin hit1 = 1'b1; idx = 4'd9; end
            8'h70: begin hit2 = 1'b1; idx = 4'd0; end
            8'h69: begin hit2 = 1'b1; idx = 4'd1; end
            8'h72: begin hit2 = 1'b1; idx = 4'd2; end
            8'h7A: begin hit2 = 1'b1; idx = 4'd3; end
            8'h6B: begin hit2 = 1'b1; idx = 4'd4; end
            8'h73: begin hit2 = 1'b1; idx = 4'd5; end
            8'h74: begin hit2 = 1'b1; idx = 4'd6; end
            8'h6C: begin hit2 = 1'b1; idx = 4'd7; end
            8'h75: begin hit2 = 1'b1; idx = 4'd8; end
            8'h7D: begin hit2 = 1'b1; idx = 4'd9; end
            default: ;
        endcase
    end

    // Zero-extended so selects 10..15 read as "not held".
    assign kp1_ext = {6'd0, kp1_state};
    assign kp2_ext = {6'd0, kp2_state};

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            prev_tog  <= 1'b0;
            primed    <= 1'b0;
            kp1_state <= '0;
            kp2_state <= '0;
            key_sel   <= 4'hF;
            ef3_n     <= 1'b1;
            ef4_n     <= 1'b1;
        end else begin
            prev_tog <= ps2_key[10];
            primed   <= 1'b1;
            if (clear_all) begin
                kp1_state <= '0;
                kp2_state <= '0;
            end else if (key_event) begin
                if (hit1) kp1_state[idx] <= ps2_key[9];
                if (hit2) kp2_state[idx] <= ps2_key[9];
            end
            if (io_out && io_n == 3'd2)
                key_sel <= io_dout[3:0];
            ef3_n <= ~kp1_ext[key_sel];
            ef4_n <= ~kp2_ext[key_sel];
        end
    end

endmodule

// File: tb/tb_studio2_keypad.sv
// Bench for studio2_keypad: table of key/OUT/clear rows with a queued expectation per row,
// plus reset/priming and async-reset-mid-hold sequences.
module tb_studio2_keypad;

    logic        clk = 1'b0;
    logic        resetq;
    logic [10:0] ps2_key;
    logic        clear_all;
    logic        io_out;
    logic [2:0]  io_n;
    logic [7:0]  io_dout;
    logic        ef3_n, ef4_n;
    logic [3:0]  key_sel;
    logic [9:0]  kp1_state, kp2_state;

    studio2_keypad dut (
        .clk(clk), .resetq(resetq), .ps2_key(ps2_key), .clear_all(clear_all),
        .io_out(io_out), .io_n(io_n), .io_dout(io_dout), .ef3_n(ef3_n), .ef4_n(ef4_n),
        .key_sel(key_sel), .kp1_state(kp1_state), .kp2_state(kp2_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         ev;
        bit         ext;
        bit         pr;
        logic [7:0] code;
        bit         clr;
        bit         out;
        logic [2:0] n;
        logic [7:0] dout;
        logic [9:0] kp1;
        logic [9:0] kp2;
        logic [3:0] sel;
        bit         ef3;
        bit         ef4;
    } row_t;

    row_t tbl[21];
    row_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic tog;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic row_t mk(input bit ev, input bit ext, input bit pr, input logic [7:0] code,
                                input bit clr, input bit out, input logic [2:0] n,
                                input logic [7:0] dout, input logic [9:0] kp1,
                                input logic [9:0] kp2, input logic [3:0] sel,
                                input bit ef3, input bit ef4);
        row_t r;
        r.ev = ev; r.ext = ext; r.pr = pr; r.code = code; r.clr = clr; r.out = out;
        r.n = n; r.dout = dout; r.kp1 = kp1; r.kp2 = kp2; r.sel = sel; r.ef3 = ef3; r.ef4 = ef4;
        return r;
    endfunction

    initial begin
        bit   pe3, pe4;
        row_t e;
        //          ev ext pr code  clr out n     dout   kp1     kp2     sel  ef3 ef4
        tbl[0]  = mk(0, 0, 0, 8'h00, 0, 1, 3'd2, 8'h35, 10'h000, 10'h000, 4'h5, 1, 1);
        tbl[1]  = mk(1, 0, 1, 8'h2E, 0, 0, 3'd0, 8'h00, 10'h020, 10'h000, 4'h5, 0, 1);
        tbl[2]  = mk(1, 0, 0, 8'h2E, 0, 0, 3'd0, 8'h00, 10'h000, 10'h000, 4'h5, 1, 1);
        tbl[3]  = mk(0, 0, 0, 8'h00, 0, 1, 3'd2, 8'h03, 10'h000, 10'h000, 4'h3, 1, 1);
        tbl[4]  = mk(1, 0, 1, 8'h6C, 0, 0, 3'd0, 8'h00, 10'h000, 10'h080, 4'h3, 1, 1);
        tbl[5]  = mk(0, 0, 0, 8'h00, 0, 1, 3'd2, 8'h07, 10'h000, 10'h080, 4'h7, 1, 0);
        tbl[6]  = mk(0, 0, 0, 8'h00, 0, 1, 3'd2, 8'h0C, 10'h000, 10'h080, 4'hC, 1, 1);
        tbl[7]  = mk(1, 1, 1, 8'h75, 0, 0, 3'd0, 8'h00, 10'h000, 10'h080, 4'hC, 1, 1);
        tbl[8]  = mk(1, 0, 1, 8'h1C, 0, 0, 3'd0, 8'h00, 10'h000, 10'h080, 4'hC, 1, 1);
        tbl[9]  = mk(0, 0, 0, 8'h00, 0, 1, 3'd1, 8'h05, 10'h000, 10'h080, 4'hC, 1, 1);
        tbl[10] = mk(0, 0, 0, 8'h00, 0, 1, 3'd2, 8'h29, 10'h000, 10'h080, 4'h9, 1, 1);
        tbl[11] = mk(1, 0, 1, 8'h16, 0, 0, 3'd0, 8'h00, 10'h002, 10'h080, 4'h9, 1, 1);
        tbl[12] = mk(1, 0, 1, 8'h46, 0, 0, 3'd0, 8'h00, 10'h202, 10'h080, 4'h9, 0, 1);
        tbl[13] = mk(1, 0, 0, 8'h16, 0, 0, 3'd0, 8'h00, 10'h200, 10'h080, 4'h9, 0, 1);
        tbl[14] = mk(1, 0, 1, 8'h46, 0, 0, 3'd0, 8'h00, 10'h200, 10'h080, 4'h9, 0, 1);
        tbl[15] = mk(1, 0, 0, 8'h3D, 0, 0, 3'd0, 8'h00, 10'h200, 10'h080, 4'h9, 0, 1);
        tbl[16] = mk(1, 0, 1, 8'h45, 1, 0, 3'd0, 8'h00, 10'h000, 10'h000, 4'h9, 1, 1);
        tbl[17] = mk(1, 0, 1, 8'h75, 0, 1, 3'd2, 8'h08, 10'h000, 10'h100, 4'h8, 1, 0);
        tbl[18] = mk(1, 0, 1, 8'h70, 0, 0, 3'd0, 8'h00, 10'h000, 10'h101, 4'h8, 1, 0);
        tbl[19] = mk(0, 0, 0, 8'h00, 0, 1, 3'd2, 8'hF0, 10'h000, 10'h101, 4'h0, 1, 0);
        tbl[20] = mk(1, 0, 1, 8'h45, 0, 0, 3'd0, 8'h00, 10'h001, 10'h101, 4'h0, 0, 0);

        // Reset with a stale toggle level and a decodable pressed code on the bus.
        tog = 1'b1;
        resetq = 1'b0; ps2_key = {1'b1, 1'b1, 1'b0, 8'h45};
        clear_all = 1'b0; io_out = 1'b0; io_n = 3'd0; io_dout = 8'h00;
        repeat (3) @(negedge clk);
        resetq = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            chk("prime_kp1", {6'd0, kp1_state}, 16'h0);
            chk("prime_ef3", {15'd0, ef3_n}, 16'h1);
            chk("prime_ef4", {15'd0, ef4_n}, 16'h1);
            chk("prime_sel", {12'd0, key_sel}, 16'hF);
        end

        pe3 = 1'b1; pe4 = 1'b1;
        for (int i = 0; i < 21; i++) begin
            if (tbl[i].ev) begin
                tog = ~tog;
                ps2_key = {tog, tbl[i].pr, tbl[i].ext, tbl[i].code};
            end
            clear_all = tbl[i].clr;
            io_out    = tbl[i].out;
            io_n      = tbl[i].n;
            io_dout   = tbl[i].dout;
            sb.push_back(tbl[i]);
            @(negedge clk);
            clear_all = 1'b0; io_out = 1'b0;
            e = sb.pop_front();
            chk($sformatf("row%0d_kp1", i), {6'd0, kp1_state}, {6'd0, e.kp1});
            chk($sformatf("row%0d_kp2", i), {6'd0, kp2_state}, {6'd0, e.kp2});
            chk($sformatf("row%0d_sel", i), {12'd0, key_sel}, {12'd0, e.sel});
            chk($sformatf("row%0d_ef3_e1", i), {15'd0, ef3_n}, {15'd0, pe3});
            chk($sformatf("row%0d_ef4_e1", i), {15'd0, ef4_n}, {15'd0, pe4});
            @(negedge clk);
            chk($sformatf("row%0d_ef3_e2", i), {15'd0, ef3_n}, {15'd0, e.ef3});
            chk($sformatf("row%0d_ef4_e2", i), {15'd0, ef4_n}, {15'd0, e.ef4});
            pe3 = e.ef3; pe4 = e.ef4;
        end

        // Short reset pulse between edges: outputs must drop without a clock edge.
        #1 resetq = 1'b0;
        #1;
        chk("areset_kp1", {6'd0, kp1_state}, 16'h0);
        chk("areset_kp2", {6'd0, kp2_state}, 16'h0);
        chk("areset_sel", {12'd0, key_sel}, 16'hF);
        chk("areset_ef3", {15'd0, ef3_n}, 16'h1);
        chk("areset_ef4", {15'd0, ef4_n}, 16'h1);
        resetq = 1'b1;
        // Toggle level unchanged and a mapped code present: priming must not decode it.
        repeat (3) @(negedge clk);
        chk("repr_kp1", {6'd0, kp1_state}, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
